emu_step_ctrl: RTL and testbench

Synthesizable, parametrised stepping controller for analog-emulation test benches, driving an emulator through reset and single-step `go` pulses. It generalises the scripted reset/step/check sequence to N_CH fixed-point channels, a runtime step count and a tolerance window, all in hardware. Per-step expected values come from an internal table. The block sits between host/VIO control and the emulator core (`go_vio`/`rst_vio`), and reports pass/fail and the first failing step.

---
 rtl/emu_step_ctrl_if.sv | 40 ++++
 rtl/emu_step_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_emu_step_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/emu_step_ctrl_if.sv
// Control/status bundle between the host (VIO/testbench) and emu_step_ctrl.
// The host drives the run controls and the emulator's measured outputs; the controller drives the rest.
interface emu_step_ctrl_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned NS_W  = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned ROW_W = N_CH * WIDTH;

    logic              start;
    logic              abort;
    logic [NS_W-1:0]   num_steps;
    logic [WIDTH-1:0]  tol;
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [ROW_W-1:0]  load_data;
    logic [ROW_W-1:0]  meas_in;
    logic              go_vio;
    logic              rst_vio;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [AW-1:0]     err_step;
    logic [CH_W-1:0]   err_ch;
    logic [AW-1:0]     step_idx;

    modport master (
        output start, abort, num_steps, tol, load_en, load_addr, load_data, meas_in,
        input  go_vio, rst_vio, busy, done, pass, err_count, err_step, err_ch, step_idx
    );

    modport slave (
        input  start, abort, num_steps, tol, load_en, load_addr, load_data, meas_in,
        output go_vio, rst_vio, busy, done, pass, err_count, err_step, err_ch, step_idx
    );
endinterface

// File: rtl/emu_step_ctrl.sv
// Reset/step sequencer for an analog emulator with per-step tolerance checks against an internal table.
// Optional EMU_STEP_CTRL_STOP_ON_FAIL_EN: end the run at the first CHECK that sees any mismatch.
module emu_step_ctrl #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned GO_HI      = 1,
    parameter int unsigned GO_LO      = 1,
    parameter int unsigned SETTLE     = 2
) (
    input  logic           emu_clk,
    input  logic           emu_rst_n,
    emu_step_ctrl_if.slave bus
);
    localparam int unsigned NS_W    = $clog2(DEPTH + 1);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned ROW_W   = N_CH * WIDTH;
    localparam int unsigned DW      = WIDTH + 1;
    localparam int unsigned MAX_A   = (RST_CYCLES > GO_HI) ? RST_CYCLES : GO_HI;
    localparam int unsigned MAX_B   = (GO_LO > SETTLE) ? GO_LO : SETTLE;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GO_HI_LOAD  = CNT_W'(GO_HI - 1);
    localparam logic [CNT_W-1:0] GO_LO_LOAD  = CNT_W'(GO_LO - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_PGO_HI, S_PGO_LO, S_SETTLE, S_CHECK, S_GO_HI, S_GO_LO, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NS_W-1:0]   n_q;
    logic [AW-1:0]     step_idx_q;
    logic              busy_q, done_q, pass_q, go_q, rst_q, err_seen_q;
    logic [15:0]       err_count_q;
    logic [AW-1:0]     err_step_q;
    logic [CH_W-1:0]   err_ch_q;
    logic [N_CH-1:0]   pend_q;
    logic [ROW_W-1:0]  mem_q [DEPTH];

    logic              start_ok_c, cnt_zero_c, last_c;
    logic [NS_W-1:0]   n_clamp_c;
    logic [ROW_W-1:0]  exp_row_c;
    logic [WIDTH-1:0]  meas_ch_c, exp_ch_c;
    logic [DW-1:0]     diff_c, mag_c;
    logic [N_CH-1:0]   fail_c;
    logic [CH_W-1:0]   first_ch_c;
    logic [16:0]       add_c, sum_c;
    logic [15:0]       err_next_c;

    assign start_ok_c = bus.start && !bus.abort && !busy_q && (state_q == S_IDLE || state_q == S_DONE);
    assign cnt_zero_c = (cnt_q == '0);
    assign last_c     = (NS_W'(step_idx_q) == n_q - NS_W'(1));
    assign n_clamp_c  = (bus.num_steps > NS_W'(DEPTH)) ? NS_W'(DEPTH) : bus.num_steps;

    // Per-channel tolerance check; one extra bit keeps meas-exp from overflowing at the extremes
    always_comb begin
        exp_row_c  = mem_q[step_idx_q];
        meas_ch_c  = '0;
        exp_ch_c   = '0;
        diff_c     = '0;
        mag_c      = '0;
        fail_c     = '0;
        first_ch_c = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            meas_ch_c = bus.meas_in[c*WIDTH +: WIDTH];
            exp_ch_c  = exp_row_c[c*WIDTH +: WIDTH];
            diff_c    = {meas_ch_c[WIDTH-1], meas_ch_c} - {exp_ch_c[WIDTH-1], exp_ch_c};
            mag_c     = diff_c[WIDTH] ? (~diff_c + DW'(1)) : diff_c;
            fail_c[c] = (mag_c > {1'b0, bus.tol});
        end
        for (int c = int'(N_CH) - 1; c >= 0; c--) begin
            if (fail_c[c]) first_ch_c = CH_W'(c);
        end
    end

    // Saturating accumulation of the previous CHECK's failing channels
    always_comb begin
        add_c = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            add_c = add_c + 17'(pend_q[c]);
        end
        sum_c      = {1'b0, err_count_q} + add_c;
        err_next_c = sum_c[16] ? 16'hFFFF : sum_c[15:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_c) begin
                    state_d = S_RST;
                    cnt_d   = RST_LOAD;
                end
            end
            S_RST: begin
                if (cnt_zero_c) begin
                    state_d = S_PGO_HI;
                    cnt_d   = GO_HI_LOAD;
                end
            end
            S_PGO_HI, S_GO_HI: begin
                if (cnt_zero_c) begin
                    state_d = (state_q == S_PGO_HI) ? S_PGO_LO : S_GO_LO;
                    cnt_d   = GO_LO_LOAD;
                end
            end
            S_PGO_LO, S_GO_LO: begin
                if (cnt_zero_c) begin
                    if ((state_q == S_PGO_LO) ? (n_q == '0) : last_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = (SETTLE == 0) ? S_CHECK : S_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_zero_c) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_GO_HI;
                cnt_d   = GO_HI_LOAD;
`ifdef EMU_STEP_CTRL_STOP_ON_FAIL_EN
                if (|fail_c) state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) state_d = S_IDLE;
    end

    // Outputs follow the state one cycle behind, so done rises one cycle after DONE entry
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            step_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            go_q        <= 1'b0;
            rst_q       <= 1'b1;
            err_seen_q  <= 1'b0;
            err_count_q <= '0;
            err_step_q  <= '0;
            err_ch_q    <= '0;
            pend_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bus.abort) begin
                go_q        <= 1'b0;
                rst_q       <= 1'b1;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                pass_q      <= 1'b0;
                err_count_q <= err_next_c;
                pend_q      <= '0;
            end else if (start_ok_c) begin
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                pass_q      <= 1'b0;
                go_q        <= 1'b0;
                rst_q       <= 1'b1;
                err_seen_q  <= 1'b0;
                err_count_q <= '0;
                err_step_q  <= '0;
                err_ch_q    <= '0;
                pend_q      <= '0;
                step_idx_q  <= '0;
                n_q         <= n_clamp_c;
            end else begin
                go_q        <= (state_q inside {S_PGO_HI, S_GO_HI});
                rst_q       <= (state_q inside {S_IDLE, S_RST, S_PGO_HI, S_PGO_LO});
                err_count_q <= err_next_c;
                pend_q      <= (state_q == S_CHECK) ? fail_c : '0;
                if (state_q == S_CHECK && |fail_c && !err_seen_q) begin
                    err_seen_q <= 1'b1;
                    err_step_q <= step_idx_q;
                    err_ch_q   <= first_ch_c;
                end
                if (state_q == S_DONE && busy_q) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_count_q == '0) && (pend_q == '0);
                end
                if (state_q == S_GO_LO && cnt_zero_c && !last_c) begin
                    step_idx_q <= step_idx_q + AW'(1);
                end
            end
        end
    end

    // Expected-value table; not reset, writable only between runs
    always_ff @(posedge emu_clk) begin
        if (bus.load_en && !busy_q) mem_q[bus.load_addr] <= bus.load_data;
    end

    assign bus.go_vio    = go_q;
    assign bus.rst_vio   = rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_step  = err_step_q;
    assign bus.err_ch    = err_ch_q;
    assign bus.step_idx  = step_idx_q;
endmodule

// File: tb/tb_emu_step_ctrl.sv
// Self-checking bench for emu_step_ctrl: an emulator stand-in advances meas_in on each go pulse,
// and each run is scored against a table-level model of the expected outcome and latency.
module tb_emu_step_ctrl;
    localparam int N_CH   = 2;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 32;
    localparam int RC     = 4;
    localparam int GH     = 1;
    localparam int GL     = 1;
    localparam int ST     = 2;
    localparam int AW     = 5;
    localparam int PER    = ST + 1 + GH + GL;
    localparam int BASE_L = RC + GH + GL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    emu_step_ctrl_if #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    emu_step_ctrl #(
        .N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH),
        .RST_CYCLES(RC), .GO_HI(GH), .GO_LO(GL), .SETTLE(ST)
    ) dut (
        .emu_clk  (clk),
        .emu_rst_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int   exp_tab  [DEPTH][N_CH];
    int   meas_tab [DEPTH][N_CH];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   go_count = 0;
    int   base     = 0;
    logic go_prev  = 1'b0;

    // Emulator stand-in: every rising go pulse advances to the next step's outputs
    always @(negedge clk) begin : emu
        int idx;
        logic [N_CH*WIDTH-1:0] row;
        if (bus.go_vio === 1'b1 && go_prev !== 1'b1) begin
            go_count++;
            idx = go_count - base - 1;
            if (idx < 0) idx = 0;
            if (idx > DEPTH - 1) idx = DEPTH - 1;
            for (int c = 0; c < N_CH; c++) row[c*WIDTH +: WIDTH] = WIDTH'(meas_tab[idx][c]);
            bus.meas_in = row;
        end
        go_prev = bus.go_vio;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/go"},       32'(bus.go_vio),    0);
        chk({tag, "/rst_vio"},  32'(bus.rst_vio),   1);
        chk({tag, "/busy"},     32'(bus.busy),      0);
        chk({tag, "/done"},     32'(bus.done),      0);
        chk({tag, "/pass"},     32'(bus.pass),      0);
        chk({tag, "/err_cnt"},  32'(bus.err_count), 0);
        chk({tag, "/err_step"}, 32'(bus.err_step),  0);
        chk({tag, "/err_ch"},   32'(bus.err_ch),    0);
        chk({tag, "/step_idx"}, 32'(bus.step_idx),  0);
    endtask

    task automatic fill(input int span, input int delta);
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                exp_tab[k][c]  = int'($urandom_range(0, 2 * span)) - span;
                meas_tab[k][c] = exp_tab[k][c] + int'($urandom_range(0, 2 * delta)) - delta;
            end
        end
    endtask

    task automatic load_table();
        logic [N_CH*WIDTH-1:0] row;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) row[c*WIDTH +: WIDTH] = WIDTH'(exp_tab[i][c]);
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(i);
            bus.load_data = row;
        end
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    task automatic start_run(input int n_req, input int tol_v);
        @(negedge clk);
        bus.num_steps = 6'(n_req);
        bus.tol       = 16'(tol_v);
        bus.start     = 1'b1;
        base          = go_count;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input int n_req, input int tol_v, input bit corrupt, input string tag);
        int n, errs, fs, fc, d, exp_l, exp_pul, exp_step, lat, rfall;
        bit stopped;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        errs = 0; fs = -1; fc = 0; stopped = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                d = meas_tab[k][c] - exp_tab[k][c];
                if (d < 0) d = -d;
                if (d > tol_v) begin
                    errs++;
                    if (fs < 0) begin fs = k; fc = c; end
                end
            end
`ifdef EMU_STEP_CTRL_STOP_ON_FAIL_EN
            if (fs >= 0) begin stopped = 1'b1; break; end
`endif
        end
        if (errs > 65535) errs = 65535;
        exp_l    = stopped ? BASE_L + fs * PER + ST + 2 : BASE_L + n * PER + 1;
        exp_pul  = stopped ? 1 + fs : 1 + n;
        exp_step = stopped ? fs : ((n > 0) ? n - 1 : 0);

        start_run(n_req, tol_v);
        chk({tag, "/busy_up"}, 32'(bus.busy), 1);
        lat = -1; rfall = -1;
        for (int k = 0; k < 4000; k++) begin
            if (k > 0) @(negedge clk);
            if (rfall < 0 && bus.rst_vio === 1'b0) rfall = k;
            if (bus.done === 1'b1) begin lat = k; break; end
            if (corrupt) begin
                bus.load_en   = 1'b1;
                bus.load_addr = AW'($urandom_range(0, DEPTH - 1));
                bus.load_data = 32'($urandom);
            end
        end
        bus.load_en = 1'b0;
        chk({tag, "/latency"},   32'(lat),           32'(exp_l));
        chk({tag, "/rst_fall"},  32'(rfall),         32'(BASE_L + 1));
        chk({tag, "/pass"},      32'(bus.pass),      32'(errs == 0));
        chk({tag, "/err_count"}, 32'(bus.err_count), 32'(errs));
        chk({tag, "/err_step"},  32'(bus.err_step),  32'((fs < 0) ? 0 : fs));
        chk({tag, "/err_ch"},    32'(bus.err_ch),    32'(fc));
        chk({tag, "/step_idx"},  32'(bus.step_idx),  32'(exp_step));
        chk({tag, "/busy_down"}, 32'(bus.busy),      0);
        chk({tag, "/pulses"},    32'(go_count - base), 32'(exp_pul));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.num_steps = '0;
        bus.tol       = '0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;

        repeat (3) @(negedge clk);
        chk_reset("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("reset_released");

        // Exact match, three steps
        fill(2000, 0);
        load_table();
        run(3, int'($urandom_range(0, 20)), 1'b0, "exact3");

        // Boundary: |diff|==tol passes, tol+1 on step 2 ch1 fails
        fill(2000, 8);
        meas_tab[0][0] = exp_tab[0][0] + 8;
        meas_tab[1][1] = exp_tab[1][1] - 8;
        meas_tab[2][1] = exp_tab[2][1] + (($urandom_range(0, 1) == 1) ? 9 : -9);
        load_table();
        run(4, 8, 1'b0, "tol_edge");

        run(0, 0, 1'b0, "n0");

        // num_steps above DEPTH is clamped
        fill(2000, 12);
        load_table();
        run(40, 10, 1'b0, "clamp40");

        // Full-scale opposite extremes on every channel
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                exp_tab[k][c]  = ((k + c) % 2 == 0) ? 32767 : -32768;
                meas_tab[k][c] = ((k + c) % 2 == 0) ? -32768 : 32767;
            end
        end
        load_table();
        run(5, int'($urandom_range(0, 1000)), 1'b0, "extremes");

        for (int r = 0; r < 4; r++) begin
            fill(3000, 20);
            load_table();
            run(int'($urandom_range(1, 10)), int'($urandom_range(0, 15)), 1'b0, "random");
        end

        // Abort while settling before the first check
        fill(2000, 0);
        load_table();
        start_run(5, 0);
        repeat (6) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort/busy",    32'(bus.busy),      0);
        chk("abort/done",    32'(bus.done),      0);
        chk("abort/rst_vio", 32'(bus.rst_vio),   1);
        chk("abort/go",      32'(bus.go_vio),    0);
        chk("abort/err_cnt", 32'(bus.err_count), 0);
        repeat (10) @(negedge clk);
        chk("abort/pulses",  32'(go_count - base), 1);
        chk("abort/idle",    32'(bus.busy),      0);

        // Asynchronous reset mid-run
        start_run(5, 0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("arst_now");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("arst_after");

        // Writes during a run are dropped; rerun confirms table intact
        run(6, 0, 1'b1, "corrupt_run");
        run(6, 0, 1'b0, "reread");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
